// File: rtl/weight_sram_arbiter.sv
// Round-robin, burst-locked arbiter sharing the weights/bias SRAM read port between conv1, conv2 and fc.
// Optional `define WSA_PERF_CNT_EN adds the cnt_clr input and the saturating wait_cnt output.
module weight_sram_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 208,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addra,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      sram_ena,
  output logic [ADDR_W-1:0]         sram_addra,
  input  logic [DATA_W-1:0]         sram_douta,
  output logic [NUM_REQ-1:0]        rd_vld,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
`ifdef WSA_PERF_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [31:0]               wait_cnt
`endif
);

  localparam int unsigned       IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned       BEAT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_REQ-1:0]  tag_q [RD_LAT];

  logic [ADDR_W-1:0]   slot_addr [NUM_REQ];
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic                issue;
  logic                contend;
  logic                tag_any;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_addr[i] = req_addra[i*ADDR_W +: ADDR_W];
    end
  end

  // Search upward from the slot after the last owner, wrapping modulo NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign issue      = |(gnt_q & req);
  assign contend    = |(req & ~gnt_q);
  assign sram_ena   = issue;
  assign sram_addra = issue ? slot_addr[owner_q] : addr_q;
  assign gnt        = gnt_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q <= S_OWN;
            gnt_q   <= NUM_REQ'(1) << win_idx;
            owner_q <= win_idx;
            ptr_q   <= win_idx;
            beat_q  <= '0;
          end
        end
        S_OWN: begin
          if (!issue) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
          end else if (beat_q == BEAT_LAST) begin
            // Burst cap: wrap and keep the port unless someone else is waiting.
            beat_q <= '0;
            if (contend) begin
              state_q <= S_IDLE;
              gnt_q   <= '0;
            end
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= sram_addra;
    end
  end

  // Tags follow each read through the SRAM latency so data returns to its issuer.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= gnt_q & req;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      tag_any = tag_any | (|tag_q[i]);
    end
  end

  assign rd_vld  = tag_q[RD_LAT-1];
  assign rd_data = (|tag_q[RD_LAT-1]) ? sram_douta : '0;
  assign busy    = (|gnt_q) | tag_any;

`ifdef WSA_PERF_CNT_EN
  logic [31:0] wait_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wait_q <= '0;
    end else if (cnt_clr) begin
      wait_q <= '0;
    end else if (contend && (wait_q != '1)) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  assign wait_cnt = wait_q;
`endif

endmodule
